// File: rtl/csr_ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csr_pkg
// Description : Shared CSR RAM widths and the request-beat record.
// Revision    : 1.0 - initial release
// ============================================================================
package csr_pkg;

    localparam int CSR_DATA_WIDTH    = 32;
    localparam int CSR_ADDRESS_WIDTH = 8;

    typedef struct packed {
        logic                         write_enable;
        logic [CSR_ADDRESS_WIDTH-1:0] address;
        logic [CSR_DATA_WIDTH-1:0]    write_data;
    } csr_req_t;

endpackage
`default_nettype wire

// File: rtl/csr_ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : csr_ram_arbiter_if
// Description : Requester channels plus the shared CSR RAM port A signals.
// Revision    : 1.0 - initial release
// ============================================================================
interface csr_ram_arbiter_if #(
    parameter int N_REQ             = 4,
    parameter int CSR_DATA_WIDTH    = csr_pkg::CSR_DATA_WIDTH,
    parameter int CSR_ADDRESS_WIDTH = csr_pkg::CSR_ADDRESS_WIDTH
);
    logic [N_REQ-1:0]                   req_valid;
    logic [N_REQ-1:0]                   req_ready;
    logic [N_REQ-1:0]                   req_lock;
    logic [N_REQ-1:0]                   req_write_enable;
    logic [N_REQ*CSR_ADDRESS_WIDTH-1:0] req_address;
    logic [N_REQ*CSR_DATA_WIDTH-1:0]    req_write_data;
    logic [N_REQ-1:0]                   rsp_valid;
    logic [CSR_DATA_WIDTH-1:0]          rsp_read_data;
    logic                               CSR_RAM_valid;
    logic                               CSR_RAM_write_enable;
    logic [CSR_ADDRESS_WIDTH-1:0]       CSR_RAM_address;
    logic [CSR_DATA_WIDTH-1:0]          CSR_RAM_write_data;
    logic [CSR_DATA_WIDTH-1:0]          CSR_RAM_read_data;

    // Arbiter side
    modport slave (
        input  req_valid, req_lock, req_write_enable, req_address, req_write_data,
        input  CSR_RAM_read_data,
        output req_ready, rsp_valid, rsp_read_data,
        output CSR_RAM_valid, CSR_RAM_write_enable, CSR_RAM_address, CSR_RAM_write_data
    );

    // Requesters and RAM side
    modport master (
        output req_valid, req_lock, req_write_enable, req_address, req_write_data,
        output CSR_RAM_read_data,
        input  req_ready, rsp_valid, rsp_read_data,
        input  CSR_RAM_valid, CSR_RAM_write_enable, CSR_RAM_address, CSR_RAM_write_data
    );
endinterface
`default_nettype wire

// File: rtl/csr_ram_arbiter_rr_select.sv
`default_nettype none
// ============================================================================
// Module      : rr_select
// Description : Rotate-priority selector: first set request at or after ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_select #(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  wire  [N_REQ-1:0] i_request,
    input  wire  [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [IDX_W-1:0] o_grant_idx,
    output logic             o_grant_any
);
    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_cand;

    // ptr < N_REQ and k < N_REQ, so one conditional subtract gives the modulo
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_grant_any = 1'b0;
        w_sum       = '0;
        w_cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(N_REQ)) begin
                w_sum = w_sum - (IDX_W+1)'(N_REQ);
            end
            w_cand = w_sum[IDX_W-1:0];
            if (!o_grant_any && i_request[w_cand]) begin
                o_grant_any     = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_grant_idx     = w_cand;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/csr_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : csr_ram_arbiter
// Description : Round-robin CSR RAM port arbiter with bounded lock and
//               fixed-latency read-response routing.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_ram_arbiter #(
    parameter int N_REQ             = 4,
    parameter int CSR_DATA_WIDTH    = csr_pkg::CSR_DATA_WIDTH,
    parameter int CSR_ADDRESS_WIDTH = csr_pkg::CSR_ADDRESS_WIDTH,
    parameter int READ_LATENCY      = 1,
    parameter int LOCK_LIMIT        = 8
) (
    input wire               clock,
    input wire               reset_n,
    csr_ram_arbiter_if.slave bus
);
    import csr_pkg::*;

    localparam int                 c_IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int                 c_CNT_W    = $clog2(LOCK_LIMIT + 1);
    localparam int                 c_TAIL     = READ_LATENCY - 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(N_REQ - 1);
    localparam logic [c_CNT_W-1:0] c_LOCK_MAX = c_CNT_W'(LOCK_LIMIT - 1);

    logic [c_IDX_W-1:0]                    r_ptr;
    logic [c_IDX_W-1:0]                    r_owner;
    logic                                  r_owner_valid;
    logic [c_CNT_W-1:0]                    r_lock_cnt;
    logic [READ_LATENCY-1:0]               r_pipe_valid;
    logic [READ_LATENCY-1:0][c_IDX_W-1:0]  r_pipe_idx;

    logic                          w_owner_hit;
    logic                          w_owner_drop;
    logic [c_IDX_W-1:0]            w_search_ptr;
    logic [N_REQ-1:0]              w_rr_grant;
    logic [c_IDX_W-1:0]            w_rr_idx;
    logic                          w_rr_any;
    logic [N_REQ-1:0]              w_grant;
    logic [c_IDX_W-1:0]            w_grant_idx;
    logic                          w_grant_any;
    logic [c_CNT_W-1:0]            w_cnt_base;
    logic                          w_lock_next;
    csr_req_t                      w_sel;
    logic [N_REQ-1:0]              w_rsp_valid;
    logic [CSR_DATA_WIDTH-1:0]     w_rsp_data;
    logic [CSR_ADDRESS_WIDTH-1:0]  w_addr_arr [N_REQ];
    logic [CSR_DATA_WIDTH-1:0]     w_wdata_arr [N_REQ];

    function automatic logic [c_IDX_W-1:0] f_wrap_inc(input logic [c_IDX_W-1:0] idx);
        return (idx == c_LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign w_addr_arr[gi]  = bus.req_address[gi*CSR_ADDRESS_WIDTH +: CSR_ADDRESS_WIDTH];
        assign w_wdata_arr[gi] = bus.req_write_data[gi*CSR_DATA_WIDTH +: CSR_DATA_WIDTH];
    end

    // A released owner hands priority to its successor in the same cycle
    assign w_owner_hit  = r_owner_valid &&  bus.req_valid[r_owner];
    assign w_owner_drop = r_owner_valid && !bus.req_valid[r_owner];
    assign w_search_ptr = w_owner_drop ? f_wrap_inc(r_owner) : r_ptr;

    rr_select #(
        .N_REQ (N_REQ),
        .IDX_W (c_IDX_W)
    ) u_rr_select (
        .i_request   (bus.req_valid),
        .i_ptr       (w_search_ptr),
        .o_grant     (w_rr_grant),
        .o_grant_idx (w_rr_idx),
        .o_grant_any (w_rr_any)
    );

    // Grant is masked while reset is asserted so the RAM port idles at once
    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        w_grant_any = 1'b0;
        if (reset_n) begin
            if (w_owner_hit) begin
                w_grant[r_owner] = 1'b1;
                w_grant_idx      = r_owner;
                w_grant_any      = 1'b1;
            end else begin
                w_grant     = w_rr_grant;
                w_grant_idx = w_rr_idx;
                w_grant_any = w_rr_any;
            end
        end
    end

    always_comb begin
        w_sel = '0;
        if (w_grant_any) begin
            w_sel.write_enable = bus.req_write_enable[w_grant_idx];
            w_sel.address      = w_addr_arr[w_grant_idx];
            w_sel.write_data   = w_wdata_arr[w_grant_idx];
        end
    end

    assign bus.req_ready            = w_grant;
    assign bus.CSR_RAM_valid        = w_grant_any;
    assign bus.CSR_RAM_write_enable = w_sel.write_enable;
    assign bus.CSR_RAM_address      = w_sel.address;
    assign bus.CSR_RAM_write_data   = w_sel.write_data;

    assign w_cnt_base  = w_owner_hit ? r_lock_cnt : '0;
    assign w_lock_next = bus.req_lock[w_grant_idx] && (w_cnt_base < c_LOCK_MAX);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr         <= '0;
            r_owner       <= '0;
            r_owner_valid <= 1'b0;
            r_lock_cnt    <= '0;
        end else if (w_grant_any) begin
            if (w_lock_next) begin
                r_owner_valid <= 1'b1;
                r_owner       <= w_grant_idx;
                r_lock_cnt    <= w_cnt_base + 1'b1;
                r_ptr         <= w_search_ptr;
            end else begin
                r_owner_valid <= 1'b0;
                r_owner       <= '0;
                r_lock_cnt    <= '0;
                r_ptr         <= f_wrap_inc(w_grant_idx);
            end
        end else if (w_owner_drop) begin
            r_owner_valid <= 1'b0;
            r_owner       <= '0;
            r_lock_cnt    <= '0;
            r_ptr         <= w_search_ptr;
        end
    end

    // Tags of accepted reads travel alongside the RAM read latency
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pipe_valid <= '0;
            r_pipe_idx   <= '0;
        end else begin
            r_pipe_valid[0] <= w_grant_any && !w_sel.write_enable;
            r_pipe_idx[0]   <= w_grant_idx;
            for (int s = 1; s < READ_LATENCY; s++) begin
                r_pipe_valid[s] <= r_pipe_valid[s-1];
                r_pipe_idx[s]   <= r_pipe_idx[s-1];
            end
        end
    end

    always_comb begin
        w_rsp_valid = '0;
        w_rsp_data  = '0;
        if (r_pipe_valid[c_TAIL]) begin
            w_rsp_valid[r_pipe_idx[c_TAIL]] = 1'b1;
            w_rsp_data                      = bus.CSR_RAM_read_data;
        end
    end

    assign bus.rsp_valid     = w_rsp_valid;
    assign bus.rsp_read_data = w_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_csr_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_ram_arbiter
// Description : Directed bench with read-response scoreboard for the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_ram_arbiter;
    localparam int             c_N   = 4;
    localparam int             c_DW  = 32;
    localparam int             c_AW  = 8;
    localparam logic [c_N-1:0] c_ONE = 4'b0001;

    typedef struct packed {
        logic [c_N-1:0]  who;
        logic [c_DW-1:0] data;
    } exp_t;

    logic clock = 1'b0;
    logic rst1_n;
    logic rst2_n;
    int   n_pass  = 0;
    int   n_total = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    always #5 clock = ~clock;

    csr_ram_arbiter_if #(.N_REQ(c_N), .CSR_DATA_WIDTH(c_DW), .CSR_ADDRESS_WIDTH(c_AW)) bus1 ();
    csr_ram_arbiter_if #(.N_REQ(c_N), .CSR_DATA_WIDTH(c_DW), .CSR_ADDRESS_WIDTH(c_AW)) bus2 ();

    csr_ram_arbiter #(
        .N_REQ(c_N), .CSR_DATA_WIDTH(c_DW), .CSR_ADDRESS_WIDTH(c_AW),
        .READ_LATENCY(1), .LOCK_LIMIT(8)
    ) u_dut1 (
        .clock   (clock),
        .reset_n (rst1_n),
        .bus     (bus1)
    );

    csr_ram_arbiter #(
        .N_REQ(c_N), .CSR_DATA_WIDTH(c_DW), .CSR_ADDRESS_WIDTH(c_AW),
        .READ_LATENCY(2), .LOCK_LIMIT(8)
    ) u_dut2 (
        .clock   (clock),
        .reset_n (rst2_n),
        .bus     (bus2)
    );

    // Single-cycle RAM for the main instance, preloaded with mem[a] = a
    logic [c_DW-1:0] mem [256];
    logic [c_DW-1:0] ram1_q = '0;
    initial for (int i = 0; i < 256; i++) mem[i] = i;
    always @(posedge clock) begin
        if (bus1.CSR_RAM_valid) begin
            if (bus1.CSR_RAM_write_enable) mem[bus1.CSR_RAM_address] <= bus1.CSR_RAM_write_data;
            else                           ram1_q <= mem[bus1.CSR_RAM_address];
        end
    end
    assign bus1.CSR_RAM_read_data = ram1_q;

    // Two-cycle RAM for the second instance, returns A500_00aa
    logic [c_DW-1:0] r2_s1 = '0;
    logic [c_DW-1:0] r2_s2 = '0;
    always @(posedge clock) begin
        r2_s1 <= 32'hA500_0000 | 32'(bus2.CSR_RAM_address);
        r2_s2 <= r2_s1;
    end
    assign bus2.CSR_RAM_read_data = r2_s2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic lk, input logic we,
                           input logic [c_AW-1:0] a, input logic [c_DW-1:0] wd);
        bus1.req_valid[i]                    = v;
        bus1.req_lock[i]                     = lk;
        bus1.req_write_enable[i]             = we;
        bus1.req_address[i*c_AW +: c_AW]     = a;
        bus1.req_write_data[i*c_DW +: c_DW]  = wd;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Checks the grant mid-cycle and queues the read response it implies
    task automatic expect_grant(input string tag, input int g, input logic [c_AW-1:0] addr,
                                input logic we, input logic [c_DW-1:0] rdata);
        exp_t e;
        #2;
        chk({tag, "_ready"}, 64'(bus1.req_ready), 64'(c_ONE << g));
        chk({tag, "_addr"}, 64'(bus1.CSR_RAM_address), 64'(addr));
        if (!we) begin
            e.who  = c_ONE << g;
            e.data = rdata;
            sb_q.push_back(e);
        end
    endtask

    always @(negedge clock) begin
        if (rst1_n === 1'b1) begin
            if (bus1.rsp_valid != '0) begin
                if (sb_q.size() == 0) begin
                    chk("rsp_unexpected", 64'(bus1.rsp_valid), 64'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("rsp_who", 64'(bus1.rsp_valid), 64'(mon_e.who));
                    chk("rsp_data", 64'(bus1.rsp_read_data), 64'(mon_e.data));
                end
            end else begin
                chk("rsp_data_idle", 64'(bus1.rsp_read_data), 64'd0);
            end
        end
    end

    initial begin
        rst1_n = 1'b1;
        rst2_n = 1'b1;
        for (int i = 0; i < c_N; i++) set_req(i, 1'b0, 1'b0, 1'b0, '0, '0);
        bus2.req_valid        = '0;
        bus2.req_lock         = '0;
        bus2.req_write_enable = '0;
        bus2.req_address      = '0;
        bus2.req_write_data   = '0;
        #1;
        rst1_n = 1'b0;
        rst2_n = 1'b0;
        #2;
        chk("rst_ready", 64'(bus1.req_ready), 64'd0);
        chk("rst_ram_valid", 64'(bus1.CSR_RAM_valid), 64'd0);
        chk("rst_ram_we", 64'(bus1.CSR_RAM_write_enable), 64'd0);
        chk("rst_ram_addr", 64'(bus1.CSR_RAM_address), 64'd0);
        chk("rst_ram_wdata", 64'(bus1.CSR_RAM_write_data), 64'd0);
        chk("rst_rsp_valid", 64'(bus1.rsp_valid), 64'd0);
        repeat (2) @(posedge clock);
        #3;
        rst1_n = 1'b1;
        rst2_n = 1'b1;

        repeat (20) begin
            @(posedge clock);
            #3;
            chk("idle", 64'({bus1.CSR_RAM_valid, bus1.req_ready, bus1.rsp_valid}), 64'd0);
        end

        // All four reading: strict rotation 0,1,2,3,0,...
        next_cycle();
        for (int i = 0; i < c_N; i++) set_req(i, 1'b1, 1'b0, 1'b0, 8'(16 * (i + 1)), '0);
        for (int c = 0; c < 8; c++) begin
            expect_grant("rr", c % 4, 8'(16 * (c % 4 + 1)), 1'b0, 32'(16 * (c % 4 + 1)));
            next_cycle();
        end
        for (int i = 0; i < c_N; i++) set_req(i, 1'b0, 1'b0, 1'b0, '0, '0);
        next_cycle();

        // Requester 2 locked for 12 beats against requester 0
        set_req(2, 1'b1, 1'b1, 1'b0, 8'h30, '0);
        for (int c = 1; c <= 14; c++) begin
            int g;
            if (c == 2)  set_req(0, 1'b1, 1'b0, 1'b0, 8'h10, '0);
            if (c == 14) set_req(2, 1'b0, 1'b0, 1'b0, '0, '0);
            g = (c == 9 || c == 14) ? 0 : 2;
            expect_grant("lock", g, (g == 2) ? 8'h30 : 8'h10, 1'b0, (g == 2) ? 32'h30 : 32'h10);
            next_cycle();
        end
        set_req(0, 1'b0, 1'b0, 1'b0, '0, '0);
        next_cycle();

        // Write from 1 followed by a read of the same word from 3
        set_req(1, 1'b1, 1'b0, 1'b1, 8'h05, 32'hDEAD_BEEF);
        expect_grant("wr", 1, 8'h05, 1'b1, '0);
        chk("wr_we", 64'(bus1.CSR_RAM_write_enable), 64'd1);
        chk("wr_wdata", 64'(bus1.CSR_RAM_write_data), 64'hDEAD_BEEF);
        next_cycle();
        set_req(1, 1'b0, 1'b0, 1'b0, '0, '0);
        set_req(3, 1'b1, 1'b0, 1'b0, 8'h05, '0);
        expect_grant("rd", 3, 8'h05, 1'b0, 32'hDEAD_BEEF);
        chk("rd_we", 64'(bus1.CSR_RAM_write_enable), 64'd0);
        next_cycle();
        set_req(3, 1'b0, 1'b0, 1'b0, '0, '0);

        // Sole requester 1 with ptr=2 wraps, ptr then stays at 2
        set_req(1, 1'b1, 1'b0, 1'b0, 8'h20, '0);
        expect_grant("wrap_a", 1, 8'h20, 1'b0, 32'h20);
        next_cycle();
        expect_grant("wrap_b", 1, 8'h20, 1'b0, 32'h20);
        next_cycle();
        for (int i = 0; i < c_N; i++) set_req(i, 1'b1, 1'b0, 1'b0, 8'(16 * (i + 1)), '0);
        expect_grant("wrap_ptr", 2, 8'h30, 1'b0, 32'h30);
        next_cycle();
        for (int i = 0; i < c_N; i++) set_req(i, 1'b0, 1'b0, 1'b0, '0, '0);
        next_cycle();
        next_cycle();

        // READ_LATENCY=2 instance: latency, then reset with a read in flight
        bus2.req_address[7:0] = 8'h07;
        bus2.req_valid        = 4'b0001;
        #2;
        chk("rl2_ready", 64'(bus2.req_ready), 64'h1);
        next_cycle();
        bus2.req_valid = '0;
        #2;
        chk("rl2_early", 64'(bus2.rsp_valid), 64'd0);
        @(posedge clock);
        #3;
        chk("rl2_rsp", 64'(bus2.rsp_valid), 64'h1);
        chk("rl2_data", 64'(bus2.rsp_read_data), 64'hA500_0007);
        next_cycle();
        bus2.req_valid = 4'b0001;
        #2;
        chk("rl2_ready2", 64'(bus2.req_ready), 64'h1);
        next_cycle();
        #1;
        rst2_n = 1'b0;
        #1;
        chk("arst_ready", 64'(bus2.req_ready), 64'd0);
        chk("arst_ram_valid", 64'(bus2.CSR_RAM_valid), 64'd0);
        chk("arst_ram_addr", 64'(bus2.CSR_RAM_address), 64'd0);
        chk("arst_rsp", 64'(bus2.rsp_valid), 64'd0);
        next_cycle();
        bus2.req_valid = '0;
        @(posedge clock);
        #3;
        rst2_n = 1'b1;
        repeat (5) begin
            @(posedge clock);
            #3;
            chk("arst_no_rsp", 64'({bus2.rsp_valid, bus2.rsp_read_data}), 64'd0);
        end

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/csr_ram_arbiter.md
Name: csr_ram_arbiter

Overview:
Round-robin arbiter that shares the application-side CSR RAM port (DPRAM port A) between N_REQ application requesters. Each requester gets a valid/ready request channel and a read-response channel. The block sits between application sub-blocks and the CSR_RAM_* port of the application. It routes read data back to the issuing requester after the fixed RAM read latency. An optional lock lets a requester issue back-to-back beats, bounded by a hold limit.

Parameters:
N_REQ, 4, number of requesters (≥2)
CSR_DATA_WIDTH, 32, RAM data width
CSR_ADDRESS_WIDTH, 8, RAM word-address width
READ_LATENCY, 1, cycles from an accepted read on the RAM port to valid CSR_RAM_read_data (≥1)
LOCK_LIMIT, 8, maximum consecutive grants to one locked requester before forced rotation (≥1)

Ports:
clock  in  1  AXI clock domain
reset_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  per-requester accept; one-hot or zero
req_lock  in  N_REQ  hold grant for the next beat while asserted
req_write_enable  in  N_REQ  1=write, 0=read
req_address  in  N_REQ*CSR_ADDRESS_WIDTH  packed word addresses, requester i at slice i
req_write_data  in  N_REQ*CSR_DATA_WIDTH  packed write data
rsp_valid  out  N_REQ  one-cycle read-data strobe per requester
rsp_read_data  out  CSR_DATA_WIDTH  read data, shared; qualified by rsp_valid
CSR_RAM_valid  out  1  RAM enable
CSR_RAM_write_enable  out  1  RAM write enable
CSR_RAM_address  out  CSR_ADDRESS_WIDTH  RAM address
CSR_RAM_write_data  out  CSR_DATA_WIDTH  RAM write data
CSR_RAM_read_data  in  CSR_DATA_WIDTH  RAM read data

Behaviour:
- Reset (reset_n=0, asynchronous):
  - Priority pointer = 0, owner register cleared, lock counter = 0, response pipeline cleared.
  - rsp_valid=0 and req_ready=0.
  - CSR_RAM_valid, CSR_RAM_write_enable, CSR_RAM_address and CSR_RAM_write_data = 0.
- Grant is combinational from registered state and current req_valid. At most one requester is granted per cycle.
  - Owner path: if an owner is held and its req_valid=1, the owner is granted.
  - Round-robin path: otherwise grant the first requester with req_valid=1, searching from pointer ptr and wrapping N_REQ-1 → 0.
- Granted requester g:
  - req_ready[g]=1.
  - CSR_RAM_valid=1; CSR_RAM_write_enable, CSR_RAM_address and CSR_RAM_write_data are muxed from slice g.
  - With no grant: CSR_RAM_valid=0 and the other RAM outputs are 0.
- Request acceptance (valid & ready) on edge, with g granted:
  - req_lock[g]=1 and lock count < LOCK_LIMIT-1: the owner becomes g, the count increments, and ptr is unchanged.
  - Otherwise the owner is cleared, the count resets to 0, and ptr ← (g+1) mod N_REQ.
- Owner release:
  - A held owner that drops req_valid in a cycle is released. No grant is lost: round-robin applies in that same cycle, and ptr ← owner+1.
  - Reaching LOCK_LIMIT forces rotation even with req_lock=1, so a single requester never holds more than LOCK_LIMIT consecutive grants.
- Writes complete on acceptance and produce no response.
- Read response path:
  - Each accepted read pushes {valid, g} into a READ_LATENCY-deep shift register.
  - At the tail, rsp_valid[g] pulses for 1 cycle and rsp_read_data = CSR_RAM_read_data.
  - rsp_read_data = 0 when no rsp_valid.
  - Throughput is 1 read/cycle; no back-pressure on responses; requesters must sink them.
- Request stability: requesters hold request fields stable while valid and not ready. The arbiter does not check this.
- A same-cycle read and write cannot collide, since only one grant is possible.
- Reset mid-operation discards in-flight read responses: no rsp_valid after reset release for pre-reset reads.
- Width rules:
  - Pointer/owner index width = $clog2(N_REQ).
  - Lock counter width = $clog2(LOCK_LIMIT+1).
  - Pointer increment wraps modulo N_REQ, including non-power-of-2 N_REQ.

Decomposition:
- Shared package csr_pkg holds: CSR_DATA_WIDTH/CSR_ADDRESS_WIDTH defaults, and typedef csr_req_t {write_enable, address, write_data}.
- The pure-combinational rotate-priority selector is one natural sub-module: rr_select (inputs request vector and ptr; outputs one-hot grant and index).

Test Plan:
- Reset then idle, all req_valid=0 → CSR_RAM_valid=0, req_ready=0, rsp_valid=0 for 20 cycles.
- All four requesters reading continuously at addresses 0x10,0x20,0x30,0x40, RAM model returns address → grants 0,1,2,3,0…; rsp_valid[i] one cycle after its grant, with rsp_read_data=0x10·(i+1).
- Requester 2 locked reading 12 beats, requester 0 valid, LOCK_LIMIT=8 → req 2 gets 8 consecutive grants, then req 0 gets one, then req 2 resumes.
- Requester 1 writes 0xDEADBEEF to 0x05 while requester 3 reads 0x05 the next cycle → write accepted first, then the read returns 0xDEADBEEF on rsp_valid[3]; no rsp_valid[1].
- Requester 1 is the only valid requester after ptr=2 → grant wraps to 1 in the same cycle; ptr becomes 2.
- Assert reset_n=0 asynchronously one cycle after a read grant (READ_LATENCY=2) → outputs zero immediately; no rsp_valid after release.
